// File: rtl/alu_cmd_sequencer.sv
// Packet-level controller between UART byte streams and a shared multi-cycle ALU.
// Echo packets stream payload RX->TX; arithmetic packets fold operands into a 32-bit result.
module alu_cmd_sequencer #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hAD,
  parameter logic [7:0] OP_MUL  = 8'h88,
  parameter logic [7:0] OP_DIV  = 8'h89
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_result_valid_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    S_HDR0     = 4'd0,
    S_HDR1     = 4'd1,
    S_HDR2     = 4'd2,
    S_HDR3     = 4'd3,
    S_ECHO     = 4'd4,
    S_OPND     = 4'd5,
    S_ALU_REQ  = 4'd6,
    S_ALU_WAIT = 4'd7,
    S_SEND     = 4'd8,
    S_DRAIN    = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        first_q, first_d;
  logic        err_q, err_d;

  logic        rx_fire_s;
  logic        tx_fire_s;
  logic [15:0] len_s;
  logic [15:0] rem_load_s;
  logic        is_arith_s;
  logic        is_known_s;
  logic        malformed_s;
  logic [31:0] opnd_full_s;

  function automatic logic [1:0] alu_op_of(input logic [7:0] op);
    logic [1:0] code;
    case (op)
      OP_ADD:  code = 2'd0;
      OP_MUL:  code = 2'd1;
      OP_DIV:  code = 2'd2;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

  assign rx_fire_s   = rx_valid_i & rx_ready_o;
  assign tx_fire_s   = tx_valid_o & tx_ready_i;
  assign len_s       = {rx_data_i, len_lo_q};
  assign rem_load_s  = (len_s < 16'd4) ? 16'd0 : (len_s - 16'd4);
  assign is_arith_s  = (opcode_q == OP_ADD) || (opcode_q == OP_MUL) || (opcode_q == OP_DIV);
  assign is_known_s  = is_arith_s || (opcode_q == OP_ECHO);
  // LEN%4 equals (LEN-4)%4, so the low two bits of LEN decide operand alignment
  assign malformed_s = (len_s < 16'd4) || !is_known_s ||
                       (is_arith_s && ((len_s < 16'd8) || (len_s[1:0] != 2'b00)));
  assign opnd_full_s = {rx_data_i, opnd_q[31:8]};
  assign busy_o      = (state_q != S_HDR0);
  assign err_o       = err_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_HDR0;
      opcode_q   <= 8'h00;
      len_lo_q   <= 8'h00;
      rem_q      <= 16'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 32'd0;
      byte_cnt_q <= 2'd0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      byte_cnt_q <= byte_cnt_d;
      first_q    <= first_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    len_lo_d   = len_lo_q;
    rem_d      = rem_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    byte_cnt_d = byte_cnt_q;
    first_d    = first_q;
    err_d      = 1'b0;
    case (state_q)
      S_HDR0: begin
        if (rx_fire_s) begin
          opcode_d = rx_data_i;
          state_d  = S_HDR1;
        end else begin
          state_d  = S_HDR0;
        end
      end
      S_HDR1: begin
        state_d = rx_fire_s ? S_HDR2 : S_HDR1;
      end
      S_HDR2: begin
        if (rx_fire_s) begin
          len_lo_d = rx_data_i;
          state_d  = S_HDR3;
        end else begin
          state_d  = S_HDR2;
        end
      end
      S_HDR3: begin
        if (rx_fire_s) begin
          rem_d      = rem_load_s;
          byte_cnt_d = 2'd0;
          first_d    = 1'b1;
          if (malformed_s) begin
            err_d   = 1'b1;
            state_d = (rem_load_s != 16'd0) ? S_DRAIN : S_HDR0;
          end else if (opcode_q == OP_ECHO) begin
            state_d = (rem_load_s != 16'd0) ? S_ECHO : S_HDR0;
          end else begin
            state_d = S_OPND;
          end
        end else begin
          state_d = S_HDR3;
        end
      end
      S_ECHO, S_DRAIN: begin
        if (rx_fire_s) begin
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_HDR0 : state_q;
        end else begin
          state_d = state_q;
        end
      end
      S_OPND: begin
        if (rx_fire_s) begin
          rem_d      = rem_q - 16'd1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          opnd_d     = opnd_full_s;
          if (byte_cnt_q != 2'd3) begin
            state_d = S_OPND;
          end else if (first_q) begin
            // the first operand seeds the accumulator without an ALU round trip
            acc_d   = opnd_full_s;
            first_d = 1'b0;
            state_d = (rem_q == 16'd1) ? S_SEND : S_OPND;
          end else begin
            state_d = S_ALU_REQ;
          end
        end else begin
          state_d = S_OPND;
        end
      end
      S_ALU_REQ: begin
        state_d = alu_ready_i ? S_ALU_WAIT : S_ALU_REQ;
      end
      S_ALU_WAIT: begin
        if (alu_result_valid_i) begin
          acc_d   = alu_result_i;
          state_d = (rem_q == 16'd0) ? S_SEND : S_OPND;
        end else begin
          state_d = S_ALU_WAIT;
        end
      end
      S_SEND: begin
        if (tx_fire_s) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          state_d    = (byte_cnt_q == 2'd3) ? S_HDR0 : S_SEND;
        end else begin
          state_d    = S_SEND;
        end
      end
      default: begin
        state_d = S_HDR0;
      end
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    rx_ready_o  = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    alu_valid_o = 1'b0;
    alu_op_o    = 2'd0;
    alu_a_o     = 32'd0;
    alu_b_o     = 32'd0;
    case (state_q)
      S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_OPND, S_DRAIN: begin
        rx_ready_o = 1'b1;
      end
      S_ECHO: begin
        // zero-latency pass-through: RX only advances when TX can take the byte
        rx_ready_o = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
      S_ALU_REQ: begin
        alu_valid_o = 1'b1;
        alu_op_o    = alu_op_of(opcode_q);
        alu_a_o     = acc_q;
        alu_b_o     = opnd_q;
      end
      S_SEND: begin
        tx_valid_o = 1'b1;
        case (byte_cnt_q)
          2'd0:    tx_data_o = acc_q[7:0];
          2'd1:    tx_data_o = acc_q[15:8];
          2'd2:    tx_data_o = acc_q[23:16];
          default: tx_data_o = acc_q[31:24];
        endcase
      end
      default: begin
        rx_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed packets from the test plan plus
// randomized packets checked against a packet-level reference model.
module tb_alu_cmd_sequencer;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;
  localparam logic [7:0] OP_DIV  = 8'h89;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic [31:0] alu_result_i;
  logic        alu_result_valid_i;
  logic        busy_o, err_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] pkt[$];
  logic [7:0] tx_got[$];
  int err_seen, alu_reqs, tx_unstable;
  int tx_mode, alu_rdy_dly, alu_lat;
  bit rx_ready_in_alu, alu_unstable;
  logic [31:0] last_a, last_b;
  logic [1:0]  last_op;

  alu_cmd_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_result_i(alu_result_i), .alu_result_valid_i(alu_result_valid_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] alu_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: return sa + sb;
      2'd1: return sa * sb;
      2'd2: begin
        if (sb == 0) return 32'hFFFF_FFFF;
        else return sa / sb;
      end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Packet-level reference: what TX bytes, err pulses and ALU requests a packet should produce
  function automatic void model_pkt(input logic [7:0] p[$], output logic [7:0] exp_q[$],
                                    output int exp_err, output int exp_reqs);
    logic [7:0] op;
    int len, n, acc, v;
    logic [31:0] accb;
    exp_q = {};
    exp_err = 0;
    exp_reqs = 0;
    op = p[0];
    len = int'({p[3], p[2]});
    if (len < 4 || !(op inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV}) ||
        (op != OP_ECHO && (len < 8 || len % 4 != 0))) begin
      exp_err = 1;
      return;
    end
    if (op == OP_ECHO) begin
      for (int i = 4; i < len; i++) exp_q.push_back(p[i]);
      return;
    end
    n = (len - 4) / 4;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      v = int'({p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]});
      if (k == 0) acc = v;
      else if (op == OP_ADD) acc = acc + v;
      else if (op == OP_MUL) acc = acc * v;
      else acc = (v == 0) ? -1 : acc / v;
    end
    exp_reqs = n - 1;
    accb = acc;
    for (int i = 0; i < 4; i++) exp_q.push_back(accb[8*i +: 8]);
  endfunction

  function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  function automatic void pkt_hdr(input logic [7:0] op, input int len);
    pkt = {};
    pkt.push_back(op);
    pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
  endfunction

  function automatic void pkt_word(input int w);
    for (int i = 0; i < 4; i++) pkt.push_back(w[8*i +: 8]);
  endfunction

  // TX/err monitor, sampled on the falling edge
  initial begin
    logic prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk_i);
      if (tx_valid_o && tx_ready_i) tx_got.push_back(tx_data_o);
      if (err_o) err_seen++;
      if (prev_stall && busy_o && (!tx_valid_o || tx_data_o !== prev_data)) tx_unstable++;
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data = tx_data_o;
    end
  end

  // TX backpressure: 0 = always ready, 1 = toggling, else random
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (tx_mode)
        0: tx_ready_i = 1'b1;
        1: tx_ready_i = ~tx_ready_i;
        default: tx_ready_i = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Arithmetic unit stand-in with configurable accept delay and latency
  initial begin
    alu_ready_i = 1'b0;
    alu_result_valid_i = 1'b0;
    alu_result_i = 32'd0;
    forever begin
      @(posedge clk_i); #1;
      if (alu_valid_o && rst_ni) begin
        last_a = alu_a_o; last_b = alu_b_o; last_op = alu_op_o;
        alu_reqs++;
        if (rx_ready_o) rx_ready_in_alu = 1'b1;
        for (int i = 0; i < alu_rdy_dly; i++) begin
          @(posedge clk_i); #1;
          if (rst_ni && rx_ready_o) rx_ready_in_alu = 1'b1;
          if (rst_ni && (alu_a_o !== last_a || alu_b_o !== last_b || !alu_valid_o)) alu_unstable = 1'b1;
        end
        alu_ready_i = 1'b1;
        @(posedge clk_i); #1;
        alu_ready_i = 1'b0;
        for (int i = 0; i < alu_lat; i++) begin
          if (rst_ni && rx_ready_o) rx_ready_in_alu = 1'b1;
          @(posedge clk_i); #1;
        end
        if (rst_ni && rx_ready_o) rx_ready_in_alu = 1'b1;
        alu_result_valid_i = 1'b1;
        alu_result_i = alu_calc(last_op, last_a, last_b);
        @(posedge clk_i); #1;
        alu_result_valid_i = 1'b0;
        alu_result_i = $urandom;
      end
    end
  end

  task automatic send_bytes(input int max_gap, input int count);
    for (int i = 0; i < count; i++) begin
      int gap, t;
      bit ok;
      gap = $urandom_range(max_gap, 0);
      rx_valid_i = 1'b0;
      repeat (gap) begin @(posedge clk_i); #1; end
      rx_valid_i = 1'b1;
      rx_data_i = pkt[i];
      t = 0;
      ok = 1'b0;
      while (!ok && t < 2000) begin
        @(negedge clk_i);
        ok = rx_ready_o;
        @(posedge clk_i); #1;
        t++;
      end
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL rx_timeout: byte %0d rx_ready_o=%b, required 1 within 2000 cycles", i, rx_ready_o);
        rx_valid_i = 1'b0;
        return;
      end
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic run_pkt(input int max_gap);
    int t;
    tx_got = {};
    err_seen = 0;
    alu_reqs = 0;
    tx_unstable = 0;
    rx_ready_in_alu = 1'b0;
    alu_unstable = 1'b0;
    send_bytes(max_gap, pkt.size());
    t = 0;
    while (busy_o && t < 5000) begin @(posedge clk_i); #1; t++; end
    repeat (3) begin @(posedge clk_i); #1; end
    tests_run++;
    if (t >= 5000) begin
      tests_failed++;
      $display("FAIL idle_timeout: busy_o=%b after 5000 cycles, required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    logic [78:0] obs;
    rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_mode = 0;
    repeat (2) @(posedge clk_i); #1;
    obs = {rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_op_o, alu_a_o, alu_b_o, busy_o, err_o};
    tests_run++;
    if (obs !== {1'b1, 78'd0}) begin
      tests_failed++;
      $display("FAIL reset_in: outputs %h, required %h", obs, {1'b1, 78'd0});
    end
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    obs = {rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_op_o, alu_a_o, alu_b_o, busy_o, err_o};
    tests_run++;
    if (obs !== {1'b1, 78'd0}) begin
      tests_failed++;
      $display("FAIL reset_out: outputs %h, required %h", obs, {1'b1, 78'd0});
    end
  endtask

  task automatic test_echo();
    logic [7:0] exp_q[$];
    int d;
    tx_mode = 1;
    pkt = {OP_ECHO, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    exp_q = {8'h41, 8'h42, 8'h43};
    run_pkt(1);
    d = first_diff(tx_got, exp_q);
    tests_run++;
    if (d !== -1) begin
      tests_failed++;
      $display("FAIL echo_tx: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qb(tx_got, d), tx_got.size(), qb(exp_q, d), exp_q.size());
    end
    tests_run++;
    if (busy_o !== 1'b0 || tx_unstable !== 0) begin
      tests_failed++;
      $display("FAIL echo_idle: busy_o=%b tx_unstable=%0d, required 0 and 0", busy_o, tx_unstable);
    end
    pkt = {OP_ECHO, 8'h5A, 8'h04, 8'h00};
    run_pkt(0);
    tests_run++;
    if (tx_got.size() !== 0 || err_seen !== 0) begin
      tests_failed++;
      $display("FAIL echo_len4: tx bytes %0d err %0d, required 0 and 0", tx_got.size(), err_seen);
    end
  endtask

  task automatic test_add();
    logic [7:0] exp_q[$];
    int d;
    tx_mode = 0; alu_rdy_dly = 0; alu_lat = 2;
    pkt = {OP_ADD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'hFD, 8'hFF, 8'hFF, 8'hFF};
    exp_q = {8'h02, 8'h00, 8'h00, 8'h00};
    run_pkt(1);
    d = first_diff(tx_got, exp_q);
    tests_run++;
    if (d !== -1) begin
      tests_failed++;
      $display("FAIL add_tx: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qb(tx_got, d), tx_got.size(), qb(exp_q, d), exp_q.size());
    end
    tests_run++;
    if ({alu_reqs, last_op, last_a, last_b} !== {32'd1, 2'd0, 32'd5, 32'hFFFF_FFFD}) begin
      tests_failed++;
      $display("FAIL add_req: reqs %0d op %0d a %h b %h, required 1 0 00000005 fffffffd",
               alu_reqs, last_op, last_a, last_b);
    end
  endtask

  task automatic test_mul();
    logic [7:0] exp_q[$];
    int d;
    tx_mode = 0; alu_rdy_dly = 3; alu_lat = 5;
    pkt = {OP_MUL, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
           8'h04, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    exp_q = {8'hE8, 8'hFF, 8'hFF, 8'hFF};
    run_pkt(0);
    d = first_diff(tx_got, exp_q);
    tests_run++;
    if (d !== -1) begin
      tests_failed++;
      $display("FAIL mul_tx: byte %0d got %h (%0d bytes), required %h (%0d bytes)",
               d, qb(tx_got, d), tx_got.size(), qb(exp_q, d), exp_q.size());
    end
    tests_run++;
    if ({alu_reqs, last_op, rx_ready_in_alu, alu_unstable} !== {32'd2, 2'd1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mul_req: reqs %0d op %0d rx_ready_in_alu %b unstable %b, required 2 1 0 0",
               alu_reqs, last_op, rx_ready_in_alu, alu_unstable);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$];
    int d;
    tx_mode = 2; alu_rdy_dly = 0; alu_lat = 1;
    pkt = {OP_DIV, 8'h00, 8'h08, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h00};
    exp_q = {8'h2A, 8'h00, 8'h00, 8'h00};
    run_pkt(2);
    d = first_diff(tx_got, exp_q);
    tests_run++;
    if (d !== -1 || alu_reqs !== 0) begin
      tests_failed++;
      $display("FAIL single_tx: byte %0d got %h (%0d bytes) reqs %0d, required %h (%0d bytes) reqs 0",
               d, qb(tx_got, d), tx_got.size(), alu_reqs, qb(exp_q, d), exp_q.size());
    end
  endtask

  task automatic test_malformed();
    tx_mode = 0;
    pkt = {8'h77, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    run_pkt(1);
    tests_run++;
    if ({err_seen, tx_got.size(), busy_o} !== {32'd1, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL bad_opcode: err %0d tx %0d busy %b, required 1 0 0", err_seen, tx_got.size(), busy_o);
    end
    pkt = {OP_ADD, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
    run_pkt(1);
    tests_run++;
    if ({err_seen, tx_got.size(), alu_reqs} !== {32'd1, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL bad_len: err %0d tx %0d reqs %0d, required 1 0 0", err_seen, tx_got.size(), alu_reqs);
    end
    pkt = {OP_ECHO, 8'h00, 8'h02, 8'h00};
    run_pkt(0);
    tests_run++;
    if ({err_seen, tx_got.size(), busy_o} !== {32'd1, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL short_len: err %0d tx %0d busy %b, required 1 0 0", err_seen, tx_got.size(), busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int d;
    tx_mode = 0; alu_rdy_dly = 0; alu_lat = 0;
    pkt = {OP_ECHO, 8'h00, 8'h06, 8'h00, 8'hA1, 8'hA2,
           OP_ADD, 8'h00, 8'h0C, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00,
           OP_DIV, 8'h00, 8'h0C, 8'h00, 8'h9C, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h00};
    exp_q = {8'hA1, 8'hA2, 8'h10, 8'h00, 8'h00, 8'h00, 8'hF2, 8'hFF, 8'hFF, 8'hFF};
    run_pkt(0);
    d = first_diff(tx_got, exp_q);
    tests_run++;
    if (d !== -1 || alu_reqs !== 2 || err_seen !== 0) begin
      tests_failed++;
      $display("FAIL b2b_tx: byte %0d got %h (%0d bytes) reqs %0d err %0d, required %h (%0d bytes) reqs 2 err 0",
               d, qb(tx_got, d), tx_got.size(), alu_reqs, err_seen, qb(exp_q, d), exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] op;
    int exp_err, exp_reqs, kind, n, len, d, w;
    for (int it = 0; it < 40; it++) begin
      tx_mode = $urandom_range(2, 0);
      alu_rdy_dly = $urandom_range(3, 0);
      alu_lat = $urandom_range(4, 0);
      kind = $urandom_range(2, 0);
      if (kind == 0) begin
        len = $urandom_range(12, 4);
        pkt_hdr(OP_ECHO, len);
        while (pkt.size() < len) pkt.push_back(8'($urandom));
      end else if (kind == 1) begin
        case ($urandom_range(2, 0))
          0: op = OP_ADD;
          1: op = OP_MUL;
          default: op = OP_DIV;
        endcase
        n = $urandom_range(4, 1);
        pkt_hdr(op, 4 + 4 * n);
        for (int k = 0; k < n; k++) begin
          if (op != OP_DIV) w = $urandom;
          else if (k == 0) w = $urandom_range(100000, 1000);
          else w = $urandom_range(9, 1);
          if (op == OP_DIV && $urandom_range(1, 0) == 1) w = -w;
          pkt_word(w);
        end
      end else begin
        case ($urandom_range(3, 0))
          0: op = OP_ECHO;
          1: op = OP_ADD;
          2: op = OP_MUL;
          default: op = 8'($urandom);
        endcase
        len = $urandom_range(10, 0);
        pkt_hdr(op, len);
        while (pkt.size() < len) pkt.push_back(8'($urandom));
      end
      model_pkt(pkt, exp_q, exp_err, exp_reqs);
      run_pkt(2);
      d = first_diff(tx_got, exp_q);
      tests_run++;
      if (d !== -1) begin
        tests_failed++;
        $display("FAIL rand_tx[%0d]: op %h byte %0d got %h (%0d bytes), required %h (%0d bytes)",
                 it, pkt[0], d, qb(tx_got, d), tx_got.size(), qb(exp_q, d), exp_q.size());
      end
      tests_run++;
      if ({err_seen, alu_reqs, tx_unstable} !== {exp_err, exp_reqs, 32'd0}) begin
        tests_failed++;
        $display("FAIL rand_ctl[%0d]: err %0d reqs %0d unstable %0d, required %0d %0d 0",
                 it, err_seen, alu_reqs, tx_unstable, exp_err, exp_reqs);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q[$];
    logic [78:0] obs;
    int exp_err, exp_reqs, d;
    tx_mode = 0; alu_rdy_dly = 0; alu_lat = 30;
    pkt = {OP_MUL, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
           8'h04, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    send_bytes(0, 12);
    repeat (4) begin @(posedge clk_i); #1; end
    tests_run++;
    if ({busy_o, alu_valid_o, rx_ready_o} !== 3'b100) begin
      tests_failed++;
      $display("FAIL mid_wait: busy/alu_valid/rx_ready %b, required 100", {busy_o, alu_valid_o, rx_ready_o});
    end
    #2 rst_ni = 1'b0;
    #1;
    obs = {rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_op_o, alu_a_o, alu_b_o, busy_o, err_o};
    tests_run++;
    if (obs !== {1'b1, 78'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset: outputs %h, required %h", obs, {1'b1, 78'd0});
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    pkt_hdr(OP_ECHO, 10);
    while (pkt.size() < 10) pkt.push_back(8'($urandom));
    model_pkt(pkt, exp_q, exp_err, exp_reqs);
    run_pkt(1);
    d = first_diff(tx_got, exp_q);
    tests_run++;
    if (d !== -1 || err_seen !== 0) begin
      tests_failed++;
      $display("FAIL after_reset: byte %0d got %h (%0d bytes) err %0d, required %h (%0d bytes) err 0",
               d, qb(tx_got, d), tx_got.size(), err_seen, qb(exp_q, d), exp_q.size());
    end
  endtask

  initial begin
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    tx_mode = 0;
    alu_rdy_dly = 0;
    alu_lat = 1;
    err_seen = 0;
    alu_reqs = 0;
    tx_unstable = 0;
    rx_ready_in_alu = 1'b0;
    alu_unstable = 1'b0;
    test_reset();
    test_echo();
    test_add();
    test_mul();
    test_single();
    test_malformed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
